// File: rtl/axi_burst_master.sv
`timescale 1ns/1ps
// Burst master: turns one user command into an address handshake plus a data
// burst on the WR_*/RD_* slave channels, flagging ID/LAST errors and stalls.
module axi_burst_master #(
  parameter int unsigned TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic        CMD_WR,
  input  logic [31:0] CMD_ADDR,
  input  logic [7:0]  CMD_LEN,
  input  logic [3:0]  CMD_ID,
  input  logic [31:0] U_WR_DATA,
  input  logic [3:0]  U_WR_STRB,
  input  logic        U_WR_VALID,
  output logic        U_WR_READY,
  output logic [31:0] U_RD_DATA,
  output logic [3:0]  U_RD_ID,
  output logic        U_RD_LAST,
  output logic        U_RD_VALID,
  input  logic        U_RD_READY,
  output logic        DONE,
  output logic        ERR_LAST,
  output logic        ERR_ID,
  output logic        ERR_TIMEOUT,
  output logic [31:0] WR_ADDR,
  output logic [7:0]  WR_LEN,
  output logic [3:0]  WR_ID,
  output logic        WR_ADDR_VALID,
  input  logic        WR_ADDR_READY,
  output logic [31:0] WR_DATA,
  output logic [3:0]  WR_STRB,
  output logic        WR_DATA_VALID,
  output logic        WR_DATA_LAST,
  input  logic        WR_DATA_READY,
  input  logic [3:0]  WR_BACK_ID,
  output logic [31:0] RD_ADDR,
  output logic [7:0]  RD_LEN,
  output logic [3:0]  RD_ID,
  output logic        RD_ADDR_VALID,
  input  logic        RD_ADDR_READY,
  input  logic [31:0] RD_DATA,
  input  logic [3:0]  RD_BACK_ID,
  input  logic        RD_DATA_LAST,
  input  logic        RD_DATA_VALID,
  output logic        RD_DATA_READY
);
  localparam int unsigned CW = 9;
  localparam int unsigned TW = 16;
  localparam bit          TMO_EN   = (TIMEOUT != 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, WADDR, WDATA, RADDR, RDATA} state_t;

  state_t        state;
  logic [31:0]   addr_q;
  logic [7:0]    len_q;
  logic [3:0]    id_q;
  logic [CW-1:0] beat_cnt;
  logic [TW-1:0] tmo_cnt;

  logic wdata_act, rdata_act, last_beat;
  logic cmd_hs, waddr_hs, raddr_hs, wbeat, rbeat, any_hs, tmo_hit;

  assign wdata_act = (state == WDATA);
  assign rdata_act = (state == RDATA);
  assign last_beat = (beat_cnt == {1'b0, len_q});

  // Data channels are straight pass-throughs, forced low outside their phase.
  assign WR_DATA_VALID = wdata_act & U_WR_VALID;
  assign U_WR_READY    = wdata_act & WR_DATA_READY;
  assign WR_DATA       = wdata_act ? U_WR_DATA : '0;
  assign WR_STRB       = wdata_act ? U_WR_STRB : '0;
  assign WR_DATA_LAST  = wdata_act & last_beat;

  assign RD_DATA_READY = rdata_act & U_RD_READY;
  assign U_RD_VALID    = rdata_act & RD_DATA_VALID;
  assign U_RD_DATA     = rdata_act ? RD_DATA : '0;
  assign U_RD_ID       = rdata_act ? RD_BACK_ID : '0;
  assign U_RD_LAST     = rdata_act & last_beat;

  assign WR_ADDR = addr_q;
  assign WR_LEN  = len_q;
  assign WR_ID   = id_q;
  assign RD_ADDR = addr_q;
  assign RD_LEN  = len_q;
  assign RD_ID   = id_q;

  assign cmd_hs   = CMD_VALID & CMD_READY;
  assign waddr_hs = WR_ADDR_VALID & WR_ADDR_READY;
  assign raddr_hs = RD_ADDR_VALID & RD_ADDR_READY;
  assign wbeat    = WR_DATA_VALID & WR_DATA_READY;
  assign rbeat    = RD_DATA_VALID & RD_DATA_READY;
  assign any_hs   = waddr_hs | raddr_hs | wbeat | rbeat;
  assign tmo_hit  = TMO_EN && (state != IDLE) && !any_hs && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      CMD_READY     <= 1'b0;
      addr_q        <= '0;
      len_q         <= '0;
      id_q          <= '0;
      beat_cnt      <= '0;
      tmo_cnt       <= '0;
      WR_ADDR_VALID <= 1'b0;
      RD_ADDR_VALID <= 1'b0;
      DONE          <= 1'b0;
      ERR_LAST      <= 1'b0;
      ERR_ID        <= 1'b0;
      ERR_TIMEOUT   <= 1'b0;
    end else begin
      DONE        <= 1'b0;
      ERR_LAST    <= 1'b0;
      ERR_ID      <= 1'b0;
      ERR_TIMEOUT <= 1'b0;
      if (tmo_hit) begin
        // Stalled too long: drop every request and return to IDLE without DONE.
        state         <= IDLE;
        CMD_READY     <= 1'b1;
        WR_ADDR_VALID <= 1'b0;
        RD_ADDR_VALID <= 1'b0;
        ERR_TIMEOUT   <= 1'b1;
        tmo_cnt       <= '0;
        beat_cnt      <= '0;
      end else begin
        if (any_hs || state == IDLE) tmo_cnt <= '0;
        else                         tmo_cnt <= tmo_cnt + TW'(1);
        case (state)
          IDLE: begin
            if (cmd_hs) begin
              CMD_READY <= 1'b0;
              addr_q    <= CMD_ADDR;
              len_q     <= CMD_LEN;
              id_q      <= CMD_ID;
              beat_cnt  <= '0;
              if (CMD_WR) begin
                state         <= WADDR;
                WR_ADDR_VALID <= 1'b1;
              end else begin
                state         <= RADDR;
                RD_ADDR_VALID <= 1'b1;
              end
            end else begin
              CMD_READY <= 1'b1;
            end
          end
          WADDR: if (waddr_hs) begin
            WR_ADDR_VALID <= 1'b0;
            state         <= WDATA;
          end
          RADDR: if (raddr_hs) begin
            RD_ADDR_VALID <= 1'b0;
            state         <= RDATA;
          end
          WDATA: if (wbeat) begin
            if (last_beat) begin
              state     <= IDLE;
              CMD_READY <= 1'b1;
              DONE      <= 1'b1;
              ERR_ID    <= (WR_BACK_ID != id_q);
              beat_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
          RDATA: if (rbeat) begin
            // Burst length follows our own count; a wrong RD_DATA_LAST is only flagged.
            ERR_LAST <= (RD_DATA_LAST != last_beat);
            ERR_ID   <= (RD_BACK_ID != id_q);
            if (last_beat) begin
              state     <= IDLE;
              CMD_READY <= 1'b1;
              DONE      <= 1'b1;
              beat_cnt  <= '0;
            end else begin
              beat_cnt <= beat_cnt + CW'(1);
            end
          end
          default: begin
            state     <= IDLE;
            CMD_READY <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
